alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter granting two requesters access to one
// shared combinational ALU. One operation is in flight at a time. Operands
// are registered onto the ALU, held for ALU_LAT cycles, and then the result
// is captured and presented to the owning requester until it is consumed.
module alu_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  // requester 0
  input  logic        req_valid_0,
  output logic        req_ready_0,
  input  logic [3:0]  req_op_0,
  input  logic [31:0] req_a_0,
  input  logic [31:0] req_b_0,
  input  logic [31:0] req_imm_0,
  input  logic        req_src_0,
  // requester 1
  input  logic        req_valid_1,
  output logic        req_ready_1,
  input  logic [3:0]  req_op_1,
  input  logic [31:0] req_a_1,
  input  logic [31:0] req_b_1,
  input  logic [31:0] req_imm_1,
  input  logic        req_src_1,
  // shared ALU drive and return
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] alu_imm,
  output logic        alu_src,
  input  logic [31:0] alu_result,
  input  logic        alu_flag,
  // responses
  output logic        resp_valid_0,
  output logic        resp_valid_1,
  input  logic        resp_ready_0,
  input  logic        resp_ready_1,
  output logic [31:0] resp_result,
  output logic        resp_zero
);

  localparam logic [3:0] OP_SUB   = 4'b0110;
  // ISSUE waits until the counter reaches zero, so it is preloaded with
  // one less than the number of cycles the operands must sit on the ALU.
  localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        prio_r;          // 0: requester 0 wins a tie, 1: requester 1
  logic        owner_r;         // requester whose operation is in flight
  logic [3:0]  cnt_r;
  logic        gnt0_s;
  logic        gnt1_s;
  logic        hs_s;
  logic        owner_ready_s;
  logic        resp_any_s;
  logic        release_s;
  logic        resp_valid_0_r;
  logic        resp_valid_1_r;
  logic [3:0]  alu_op_r;
  logic [31:0] alu_a_r;
  logic [31:0] alu_b_r;
  logic [31:0] alu_imm_r;
  logic        alu_src_r;
  logic [31:0] resp_result_r;
  logic        resp_zero_r;

  // Combinational grant: only in IDLE; a tie is broken by the priority pointer.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (state_r == IDLE) begin
      if (req_valid_0 && req_valid_1) begin
        if (prio_r) begin
          gnt1_s = 1'b1;
        end else begin
          gnt0_s = 1'b1;
        end
      end else if (req_valid_0) begin
        gnt0_s = 1'b1;
      end else if (req_valid_1) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Handshake, owner consume and release conditions; the non-owner's
  // resp_ready never reaches the FSM.
  always_comb begin
    hs_s = gnt0_s | gnt1_s;
    if (owner_r) begin
      owner_ready_s = resp_ready_1;
    end else begin
      owner_ready_s = resp_ready_0;
    end
    resp_any_s = resp_valid_0_r | resp_valid_1_r;
    release_s  = (state_r == RESP) && resp_any_s && owner_ready_s;
  end

  // Next-state logic for the IDLE -> ISSUE -> RESP -> IDLE loop.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (cnt_r == 4'd0) begin
          state_s = RESP;
        end else begin
          state_s = ISSUE;
        end
      end
      RESP: begin
        if (release_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand registers: loaded from the winner at the handshake, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op_r  <= 4'd0;
      alu_a_r   <= 32'd0;
      alu_b_r   <= 32'd0;
      alu_imm_r <= 32'd0;
      alu_src_r <= 1'b0;
    end else if (hs_s) begin
      if (gnt1_s) begin
        alu_op_r  <= req_op_1;
        alu_a_r   <= req_a_1;
        alu_b_r   <= req_b_1;
        alu_imm_r <= req_imm_1;
        alu_src_r <= req_src_1;
      end else begin
        alu_op_r  <= req_op_0;
        alu_a_r   <= req_a_0;
        alu_b_r   <= req_b_0;
        alu_imm_r <= req_imm_0;
        alu_src_r <= req_src_0;
      end
    end else begin
      alu_op_r  <= alu_op_r;
      alu_a_r   <= alu_a_r;
      alu_b_r   <= alu_b_r;
      alu_imm_r <= alu_imm_r;
      alu_src_r <= alu_src_r;
    end
  end

  // ALU settle counter: preloaded at the handshake, counts down in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 4'd0;
    end else if (hs_s) begin
      cnt_r <= CNT_LOAD;
    end else if ((state_r == ISSUE) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Result capture once the ALU has settled; the zero flag only means
  // something for subtraction, so it is masked for every other op code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_result_r <= 32'd0;
      resp_zero_r   <= 1'b0;
    end else if ((state_r == ISSUE) && (cnt_r == 4'd0)) begin
      resp_result_r <= alu_result;
      resp_zero_r   <= (alu_op_r == OP_SUB) && alu_flag;
    end else begin
      resp_result_r <= resp_result_r;
      resp_zero_r   <= resp_zero_r;
    end
  end

  // Response valid: raised one cycle into RESP for the owner, dropped on consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_0_r <= 1'b0;
      resp_valid_1_r <= 1'b0;
    end else if (release_s) begin
      resp_valid_0_r <= 1'b0;
      resp_valid_1_r <= 1'b0;
    end else if ((state_r == RESP) && !resp_any_s) begin
      resp_valid_0_r <= ~owner_r;
      resp_valid_1_r <= owner_r;
    end else begin
      resp_valid_0_r <= resp_valid_0_r;
      resp_valid_1_r <= resp_valid_1_r;
    end
  end

  // Owner capture at the handshake and round-robin pointer update on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r <= 1'b0;
      prio_r  <= 1'b0;
    end else if (hs_s) begin
      owner_r <= gnt1_s;
      prio_r  <= prio_r;
    end else if (release_s) begin
      owner_r <= owner_r;
      prio_r  <= ~owner_r;
    end else begin
      owner_r <= owner_r;
      prio_r  <= prio_r;
    end
  end

  assign req_ready_0  = gnt0_s;
  assign req_ready_1  = gnt1_s;
  assign alu_op       = alu_op_r;
  assign alu_a        = alu_a_r;
  assign alu_b        = alu_b_r;
  assign alu_imm      = alu_imm_r;
  assign alu_src      = alu_src_r;
  assign resp_valid_0 = resp_valid_0_r;
  assign resp_valid_1 = resp_valid_1_r;
  assign resp_result  = resp_result_r;
  assign resp_zero    = resp_zero_r;

endmodule
